stdout_apb_master: RTL

Synthesizable APB master that sits directly upstream of the per-core stdout sink on the peripheral APB segment. It accepts a valid/ready stream of character records tagged with cluster and core IDs, buffers them in a small FIFO, and issues one APB write per character. The address encodes cluster and core exactly as the sink decodes them, so debug/trace sources that are not RISC-V cores (host injectors, trace collectors) can print through the same stdout path.

---
 rtl/stdout_pkg.sv | 27 ++
 rtl/stdout_fifo.sv | 63 ++++++
 rtl/stdout_apb_master.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/stdout_pkg.sv
// Shared constants and types for the stdout path (APB master and sink decoder).
// Address layout: BASE | cluster << CL_SHIFT | core << CORE_SHIFT.
package stdout_pkg;

  localparam int CL_SHIFT   = 7;
  localparam int CORE_SHIFT = 3;
  localparam int ID_WIDTH   = 4;
  localparam int CHAR_WIDTH = 8;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   cluster;
    logic [ID_WIDTH-1:0]   core;
    logic [CHAR_WIDTH-1:0] ch;
  } stdout_rec_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_t;

  // Offset of a record's sink register relative to the sink base address.
  function automatic logic [31:0] rec_offset(input stdout_rec_t rec);
    return (32'(rec.cluster) << CL_SHIFT) | (32'(rec.core) << CORE_SHIFT);
  endfunction

endpackage

// File: rtl/stdout_fifo.sv
// Small synchronous show-ahead FIFO; exposes the head and the entry behind it
// so the APB master can chain transfers without an idle cycle.
module stdout_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic             has_next,
  output logic [WIDTH-1:0] head_data,
  output logic [WIDTH-1:0] next_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [AW:0]      count_reg, count_next;
  logic             push_en, pop_en;

  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign has_next   = (count_reg >= (AW+1)'(2));
  assign push_en    = push && !full;
  assign pop_en     = pop && !empty;
  assign rd_ptr_inc = rd_ptr_reg + AW'(1);
  assign head_data  = mem[rd_ptr_reg];
  assign next_data  = mem[rd_ptr_inc];

  always_comb begin
    count_next = count_reg;
    case ({push_en, pop_en})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_en) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_en)  rd_ptr_reg <= rd_ptr_inc;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/stdout_apb_master.sv
// Character-record stream to APB write bridge feeding the per-core stdout sink.
// One APB write per buffered character; out-of-range IDs are counted and dropped.
module stdout_apb_master
  import stdout_pkg::*;
#(
  parameter int                    N_CLUSTERS = 4,
  parameter int                    N_CORES    = 8,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    FIFO_DEPTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ID_WIDTH-1:0]   req_cluster_i,
  input  logic [ID_WIDTH-1:0]   req_core_i,
  input  logic [CHAR_WIDTH-1:0] req_char_i,
  output logic                  apb_psel_o,
  output logic                  apb_penable_o,
  output logic                  apb_pwrite_o,
  output logic [ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [DATA_WIDTH-1:0] apb_pwdata_o,
  input  logic                  apb_pready_i,
  input  logic                  apb_pslverr_i,
  output logic                  busy_o,
  output logic [15:0]           drop_cnt_o,
  output logic [15:0]           err_cnt_o
);

  localparam int REC_W = $bits(stdout_rec_t);

  stdout_rec_t           in_rec, head_rec, next_rec;
  logic                  fifo_full, fifo_empty, fifo_has_next;
  logic                  accept, id_ok, push, pop, xfer_err;
  apb_state_t            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
  logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
  logic [15:0]           drop_cnt_reg, err_cnt_reg;
  logic [REC_W-1:0]      head_bits, next_bits;

  function automatic logic [ADDR_WIDTH-1:0] rec_addr(input stdout_rec_t rec);
    return BASE_ADDR | ADDR_WIDTH'(rec_offset(rec));
  endfunction

  assign in_rec = '{cluster: req_cluster_i, core: req_core_i, ch: req_char_i};
  assign head_rec = stdout_rec_t'(head_bits);
  assign next_rec = stdout_rec_t'(next_bits);

  assign id_ok = ({1'b0, req_cluster_i} < (ID_WIDTH+1)'(N_CLUSTERS)) &&
                 ({1'b0, req_core_i}    < (ID_WIDTH+1)'(N_CORES));
  assign req_ready_o = !fifo_full;
  assign accept      = req_valid_i && !fifo_full;
  assign push        = accept && id_ok;

  stdout_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (in_rec),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .has_next  (fifo_has_next),
    .head_data (head_bits),
    .next_data (next_bits)
  );

  always_comb begin
    state_next  = state_reg;
    paddr_next  = paddr_reg;
    pwdata_next = pwdata_reg;
    pop         = 1'b0;
    xfer_err    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          paddr_next  = rec_addr(head_rec);
          pwdata_next = DATA_WIDTH'(head_rec.ch);
          state_next  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (apb_pready_i) begin
          pop      = 1'b1;
          xfer_err = apb_pslverr_i;
          // Chain straight into the next SETUP only for an entry already stored.
          if (fifo_has_next) begin
            paddr_next  = rec_addr(next_rec);
            pwdata_next = DATA_WIDTH'(next_rec.ch);
            state_next  = ST_SETUP;
          end else begin
            state_next  = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg  <= ST_IDLE;
      paddr_reg  <= '0;
      pwdata_reg <= '0;
    end else begin
      state_reg  <= state_next;
      paddr_reg  <= paddr_next;
      pwdata_reg <= pwdata_next;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_cnt_reg <= '0;
      err_cnt_reg  <= '0;
    end else begin
      if (accept && !id_ok && (drop_cnt_reg != 16'hFFFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 16'd1;
      end
      if (xfer_err && (err_cnt_reg != 16'hFFFF)) begin
        err_cnt_reg <= err_cnt_reg + 16'd1;
      end
    end
  end

  assign apb_psel_o    = (state_reg != ST_IDLE);
  assign apb_penable_o = (state_reg == ST_ACCESS);
  assign apb_pwrite_o  = apb_psel_o;
  assign apb_paddr_o   = paddr_reg;
  assign apb_pwdata_o  = pwdata_reg;
  assign busy_o        = !fifo_empty || (state_reg != ST_IDLE);
  assign drop_cnt_o    = drop_cnt_reg;
  assign err_cnt_o     = err_cnt_reg;

endmodule
